// File: rtl/decoder_3_8.sv
// Registered 3-to-8 decoder: one-hot Out (or one-cold when OUT_ACTIVE_LOW), 1-cycle latency, no backpressure.
// Optional divide-by-2 clock output clkb_out is built only when DECODER_3_8_CLKDIV_EN is defined.
module decoder_3_8 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic       clka,
  input  logic       rst_n,
  input  logic       E,
  input  logic [2:0] In,
  output logic [7:0] Out,
  output logic       Out_vld
`ifdef DECODER_3_8_CLKDIV_EN
  ,
  output logic       clkb_out
`endif
);

  localparam logic [7:0] IDLE_WORD = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [7:0] one_hot;

  // In is only looked at under E, so an undriven select cannot leak into Out.
  always_comb begin
    one_hot = 8'h00;
    if (E) one_hot = 8'(1) << In;
  end

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      Out     <= IDLE_WORD;
      Out_vld <= 1'b0;
    end else begin
      Out     <= OUT_ACTIVE_LOW ? ~one_hot : one_hot;
      Out_vld <= E;
    end
  end

`ifdef DECODER_3_8_CLKDIV_EN
  always_ff @(posedge clka) begin
    if (!rst_n) clkb_out <= 1'b0;
    else        clkb_out <= ~clkb_out;
  end
`endif

endmodule

// File: tb/tb_decoder_3_8.sv
// Bench for decoder_3_8: per-cycle model check of both polarities plus directed literal vectors.
`timescale 1ns/1ps
module tb_decoder_3_8;

  logic       clka;
  logic       rst_n;
  logic       E;
  logic [2:0] In;
  logic [7:0] out_hi, out_lo;
  logic       vld_hi, vld_lo;
`ifdef DECODER_3_8_CLKDIV_EN
  logic       clkb_hi, clkb_lo;
`endif

  int n_chk = 0;
  int n_err = 0;

  localparam logic [7:0] DEC_TBL [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  decoder_3_8 #(.OUT_ACTIVE_LOW(1'b0)) u_hi (
    .clka    (clka),
    .rst_n   (rst_n),
    .E       (E),
    .In      (In),
    .Out     (out_hi),
    .Out_vld (vld_hi)
`ifdef DECODER_3_8_CLKDIV_EN
    ,
    .clkb_out(clkb_hi)
`endif
  );

  decoder_3_8 #(.OUT_ACTIVE_LOW(1'b1)) u_lo (
    .clka    (clka),
    .rst_n   (rst_n),
    .E       (E),
    .In      (In),
    .Out     (out_lo),
    .Out_vld (vld_lo)
`ifdef DECODER_3_8_CLKDIV_EN
    ,
    .clkb_out(clkb_lo)
`endif
  );

  initial begin
    clka = 1'b0;
    forever #10 clka = ~clka;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decoded word is 2**In when the sampled cycle was enabled and out of reset.
  logic       m_r, m_e;
  logic [2:0] m_in;
  logic [7:0] exp_hi, exp_lo;
  logic       exp_vld;
`ifdef DECODER_3_8_CLKDIV_EN
  logic       exp_clkb = 1'b0;
  logic       prev_clkb = 1'b0;
  realtime    last_rise = -1.0;
`endif

  always @(posedge clka) begin
    m_r  = rst_n;
    m_e  = E;
    m_in = In;
    #1;
    exp_vld = m_r && m_e;
    exp_hi  = exp_vld ? 8'(1 << m_in) : 8'h00;
    exp_lo  = 8'hFF - exp_hi;
    chk("model_out_hi", out_hi, exp_hi);
    chk("model_out_lo", out_lo, exp_lo);
    chk("model_vld_hi", {7'd0, vld_hi}, {7'd0, exp_vld});
    chk("model_vld_lo", {7'd0, vld_lo}, {7'd0, exp_vld});
    chk("active_bits_hi", 8'($countones(out_hi)), exp_vld ? 8'd1 : 8'd0);
    chk("active_bits_lo", 8'($countones(~out_lo)), exp_vld ? 8'd1 : 8'd0);
`ifdef DECODER_3_8_CLKDIV_EN
    exp_clkb = m_r ? !exp_clkb : 1'b0;
    chk("model_clkb_hi", {7'd0, clkb_hi}, {7'd0, exp_clkb});
    chk("model_clkb_lo", {7'd0, clkb_lo}, {7'd0, exp_clkb});
    if (!m_r) last_rise = -1.0;
    else if (clkb_hi && !prev_clkb) begin
      if (last_rise >= 0.0) chk("clkb_period", 8'($realtime - last_rise), 8'd40);
      last_rise = $realtime;
    end
    prev_clkb = clkb_hi;
`endif
  end

  task automatic step(input logic r, input logic e, input logic [2:0] in);
    @(negedge clka);
    rst_n = r;
    E     = e;
    In    = in;
    @(posedge clka);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    E     = 1'b1;
    In    = 3'b101;

    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 3'b101);
      chk("reset_out_hi", out_hi, 8'h00);
      chk("reset_out_lo", out_lo, 8'hFF);
      chk("reset_vld", {7'd0, vld_hi}, 8'd0);
`ifdef DECODER_3_8_CLKDIV_EN
      chk("reset_clkb", {7'd0, clkb_hi}, 8'd0);
`endif
    end

    step(1'b1, 1'b0, 3'b000);
    chk("disabled_out", out_hi, 8'h00);
    chk("disabled_vld", {7'd0, vld_hi}, 8'd0);
`ifdef DECODER_3_8_CLKDIV_EN
    chk("clkb_first_rise", {7'd0, clkb_hi}, 8'd1);
`endif

    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 3'(i));
      chk("sweep_out", out_hi, DEC_TBL[i]);
      chk("sweep_vld", {7'd0, vld_hi}, 8'd1);
    end

    step(1'b1, 1'b1, 3'b011);
    chk("enable_out", out_hi, 8'h08);
    step(1'b1, 1'b0, 3'b011);
    chk("enable_drop_out", out_hi, 8'h00);
    chk("enable_drop_vld", {7'd0, vld_hi}, 8'd0);

    step(1'b1, 1'b1, 3'b010);
    chk("low_active_out", out_lo, 8'hFB);
    step(1'b1, 1'b0, 3'b010);
    chk("low_idle_out", out_lo, 8'hFF);

    step(1'b1, 1'b0, 3'bxxx);
    chk("x_in_out_hi", out_hi, 8'h00);
    chk("x_in_out_lo", out_lo, 8'hFF);

    step(1'b1, 1'b1, 3'b110);
    chk("pre_reset_out", out_hi, 8'h40);
    step(1'b0, 1'b1, 3'b110);
    chk("mid_reset_out", out_hi, 8'h00);
    chk("mid_reset_vld", {7'd0, vld_hi}, 8'd0);
    step(1'b1, 1'b1, 3'b110);
    chk("post_reset_out", out_hi, 8'h40);
    chk("post_reset_vld", {7'd0, vld_hi}, 8'd1);

    step(1'b1, 1'b1, 3'b111);
    chk("b2b_a", out_hi, 8'h80);
    step(1'b1, 1'b1, 3'b000);
    chk("b2b_b", out_hi, 8'h01);
    step(1'b1, 1'b1, 3'b111);
    chk("b2b_c", out_hi, 8'h80);

    for (int i = 0; i < 40; i++)
      step(1'b1, 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));

    step(1'b1, 1'b0, 3'b000);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/decoder_3_8.md
DECODER_3_8 -- requirements
Module: decoder_3_8

Interface
REQ-001 The block SHALL have parameter OUT_ACTIVE_LOW, default 0, meaning 0 = one-hot active-high Out and 1 = one-cold active-low Out.
REQ-002 The block SHALL have input clka, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input rst_n, 1 bit, reset that is synchronous and active-low.
REQ-004 The block SHALL have input E, 1 bit, decode enable.
REQ-005 The block SHALL have input In, 3 bits, binary select code.
REQ-006 The block SHALL have output Out, 8 bits, the registered decoded word.
REQ-007 The block SHALL have output Out_vld, 1 bit, high when Out holds a decode of an enabled sample.
REQ-008 The block SHALL have output clkb_out, 1 bit, the divide-by-2 clock, present only when DECODER_3_8_CLKDIV_EN is defined.

Function
REQ-009 At each rising clka edge with rst_n=1 and E=1, the block SHALL load Out with bit In set and all other bits clear, for In 0..7 (active-high case).
- Example: In=3'b000 gives Out=8'h01; In=3'b111 gives Out=8'h80.
REQ-010 At a rising edge with rst_n=1 and E=0, the block SHALL load Out with all bits inactive (8'h00 when active-high) and clear Out_vld.
REQ-011 At a rising edge with rst_n=1 and E=1, the block SHALL set Out_vld to 1.
REQ-012 Latency SHALL be exactly one clka cycle from E/In sampled to Out/Out_vld updated; there SHALL be no combinational path from inputs to outputs.
REQ-013 When OUT_ACTIVE_LOW=1, the block SHALL bitwise invert every Out value listed above, including the reset and disabled values (8'hFF inactive).
REQ-014 Exactly one Out bit SHALL be active whenever Out_vld=1, and zero bits SHALL be active whenever Out_vld=0.
REQ-015 Back-to-back changes of In on consecutive cycles SHALL each be reflected on the following cycle with no dropped or merged codes.
REQ-016 X/Z on In while E=0 SHALL NOT propagate to Out.

Reset
REQ-017 On a rising clka edge with rst_n=0, the block SHALL set Out to inactive (8'h00, or 8'hFF when OUT_ACTIVE_LOW=1), Out_vld to 0, and clkb_out (if present) to 0, regardless of E and In.
REQ-018 Reset SHALL take priority over E on the same edge.
REQ-019 Reset asserted mid-operation SHALL take effect at the next edge, and the first enabled sample after release SHALL decode normally one cycle later.
REQ-020 Deassertion of rst_n between edges SHALL have no effect until the next rising edge.

Configuration
REQ-021 When macro DECODER_3_8_CLKDIV_EN is defined, the block SHALL include port clkb_out as a register that toggles on every rising clka edge while rst_n=1, giving half the clka frequency at 50% duty.
REQ-022 When DECODER_3_8_CLKDIV_EN is undefined, the block SHALL omit port clkb_out and its register entirely, and the decode behaviour SHALL be unchanged.

Verification
REQ-023 The bench SHALL hold rst_n=0 for 2 cycles with E=1 and In=3'b101 -> Out=8'h00, Out_vld=0 throughout.
REQ-024 The bench SHALL drive E=0 and In=3'b000, then E=1 with In stepping 0..7 one per cycle -> Out=8'h00 first, then 8'h01, 02, 04, 08, 10, 20, 40, 80 each one cycle after its In, with Out_vld=1.
REQ-025 The bench SHALL drive E=1 and In=3'b011, then E=0 -> Out=8'h08 then 8'h00, with Out_vld falling to 0 one cycle after E drops.
REQ-026 The bench SHALL run OUT_ACTIVE_LOW=1 with E=1 and In=3'b010 -> Out=8'hFB; with E=0 -> Out=8'hFF.
REQ-027 The bench SHALL assert rst_n=0 for one cycle mid-sequence while In=3'b110 -> Out=8'h00 on that edge, and 8'h40 one cycle after release.
REQ-028 With DECODER_3_8_CLKDIV_EN defined and clka period 20, the bench SHALL check clkb_out -> period 40, low after reset, rising at the first edge after rst_n=1.
